// File: rtl/io_sequencer_param.sv
// Key/switch driven memory I/O sequencer: chunked address/data entry, level memory
// request with optional timeout, burst auto-increment and abort.
module io_sequencer_param #(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 16,
   parameter int SW_W        = 9,
   parameter int TIMEOUT_CYC = 1024,
   // Leading chunks are 8 bits; the final chunk takes the remaining bits, up to SW_W wide.
   localparam int ADDR_CHUNKS = (ADDR_W <= SW_W) ? 1 : (ADDR_W - SW_W + 7) / 8 + 1,
   localparam int DATA_CHUNKS = (DATA_W <= SW_W) ? 1 : (DATA_W - SW_W + 7) / 8 + 1,
   localparam int MAX_CHUNKS  = (ADDR_CHUNKS > DATA_CHUNKS) ? ADDR_CHUNKS : DATA_CHUNKS,
   localparam int CIDX_W      = $clog2(MAX_CHUNKS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key0_pulse,
   input  logic              key1_pulse,
   input  logic              abort,
   input  logic [SW_W-1:0]   sw,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] read_data,
   output logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              mem_req,
   output logic [DATA_W-1:0] display_data,
   output logic [CIDX_W-1:0] chunk_idx,
   output logic              err,
   output logic [2:0]        state_out
);

   localparam int ADDR_LAST_W = ADDR_W - 8 * (ADDR_CHUNKS - 1);
   localparam int DATA_LAST_W = DATA_W - 8 * (DATA_CHUNKS - 1);
   localparam int TMR_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SEL_READ   = 3'd1,
      S_SEL_WRITE  = 3'd2,
      S_ADDR_ENTRY = 3'd3,
      S_DATA_ENTRY = 3'd4,
      S_MEM_WAIT   = 3'd5,
      S_READ_DONE  = 3'd6,
      S_ERROR      = 3'd7
   } state_t;

   state_t            r_state;
   logic              r_dir;        // 1 = write
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_write_data;
   logic [DATA_W-1:0] r_display_data;
   logic [CIDX_W-1:0] r_chunk_idx;
   logic [TMR_W-1:0]  r_tmr;

   logic              w_key1;
   logic [ADDR_W-1:0] w_addr_ins;
   logic [DATA_W-1:0] w_data_ins;
   logic              w_addr_last;
   logic              w_data_last;
   logic              w_timeout;
   logic [1:0]        w_mode;

   // key0 wins a simultaneous press, so key1 only counts on its own.
   assign w_key1      = key1_pulse & ~key0_pulse;
   assign w_addr_last = (r_chunk_idx == CIDX_W'(ADDR_CHUNKS - 1));
   assign w_data_last = (r_chunk_idx == CIDX_W'(DATA_CHUNKS - 1));
   assign w_timeout   = (TIMEOUT_CYC != 0) && (r_tmr == TMR_W'(TIMEOUT_CYC - 1));

   always_comb begin
      w_addr_ins = r_mem_addr;
      for (int i = 0; i < ADDR_CHUNKS - 1; i++)
         if (r_chunk_idx == CIDX_W'(i)) w_addr_ins[8*i +: 8] = sw[7:0];
      if (w_addr_last) w_addr_ins[ADDR_W-1 -: ADDR_LAST_W] = sw[ADDR_LAST_W-1:0];
   end

   always_comb begin
      w_data_ins = r_write_data;
      for (int i = 0; i < DATA_CHUNKS - 1; i++)
         if (r_chunk_idx == CIDX_W'(i)) w_data_ins[8*i +: 8] = sw[7:0];
      if (w_data_last) w_data_ins[DATA_W-1 -: DATA_LAST_W] = sw[DATA_LAST_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_dir          <= 1'b0;
         r_mem_addr     <= '0;
         r_write_data   <= '0;
         r_display_data <= '0;
         r_chunk_idx    <= '0;
         r_tmr          <= '0;
      end else if (abort) begin
         r_state      <= S_IDLE;
         r_mem_addr   <= '0;
         r_write_data <= '0;
         r_chunk_idx  <= '0;
         r_tmr        <= '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (key0_pulse) r_state <= S_SEL_READ;
            S_SEL_READ, S_SEL_WRITE:
               if (key0_pulse) begin
                  r_state <= (r_state == S_SEL_READ) ? S_SEL_WRITE : S_SEL_READ;
               end else if (key1_pulse) begin
                  r_dir       <= (r_state == S_SEL_WRITE);
                  r_state     <= S_ADDR_ENTRY;
                  r_chunk_idx <= '0;
                  r_mem_addr  <= '0;
               end
            S_ADDR_ENTRY:
               if (w_key1) begin
                  r_mem_addr  <= w_addr_ins;
                  r_chunk_idx <= r_chunk_idx + 1'b1;
                  if (w_addr_last) begin
                     if (r_dir) begin
                        r_state     <= S_DATA_ENTRY;
                        r_chunk_idx <= '0;
                     end else begin
                        r_state <= S_MEM_WAIT;
                        r_tmr   <= '0;
                     end
                  end
               end
            S_DATA_ENTRY:
               if (key0_pulse) begin
                  if (r_chunk_idx == '0) r_state <= S_IDLE;
               end else if (key1_pulse) begin
                  r_write_data <= w_data_ins;
                  r_chunk_idx  <= r_chunk_idx + 1'b1;
                  if (w_data_last) begin
                     r_state <= S_MEM_WAIT;
                     r_tmr   <= '0;
                  end
               end
            S_MEM_WAIT:
               if (mem_done) begin
                  if (r_dir) begin
                     r_mem_addr  <= r_mem_addr + 1'b1;
                     r_chunk_idx <= '0;
                     r_state     <= S_DATA_ENTRY;
                  end else begin
                     r_display_data <= read_data;
                     r_state        <= S_READ_DONE;
                  end
               end else if (w_timeout) begin
                  r_state <= S_ERROR;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            S_READ_DONE:
               if (key0_pulse) begin
                  r_state    <= S_IDLE;
                  r_mem_addr <= '0;
               end else if (key1_pulse) begin
                  r_mem_addr <= r_mem_addr + 1'b1;
                  r_tmr      <= '0;
                  r_state    <= S_MEM_WAIT;
               end
            S_ERROR:
               if (key0_pulse) begin
                  r_state      <= S_IDLE;
                  r_mem_addr   <= '0;
                  r_write_data <= '0;
               end
            default:
               r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_mode = 2'b00;
      case (r_state)
         S_SEL_READ:               w_mode = 2'b01;
         S_SEL_WRITE:              w_mode = 2'b10;
         S_DATA_ENTRY:             w_mode = 2'b10;
         S_ADDR_ENTRY, S_MEM_WAIT: w_mode = r_dir ? 2'b10 : 2'b01;
         S_ERROR:                  w_mode = 2'b11;
         default:                  w_mode = 2'b00;
      endcase
   end

   assign mode         = w_mode;
   assign mem_addr     = r_mem_addr;
   assign write_data   = r_write_data;
   assign mem_req      = (r_state == S_MEM_WAIT);
   assign display_data = r_display_data;
   assign chunk_idx    = r_chunk_idx;
   assign err          = (r_state == S_ERROR);
   assign state_out    = r_state;

endmodule

// File: tb/tb_io_sequencer_param.sv
// Directed bench for io_sequencer_param: a 25/16-bit instance with an 8-cycle timeout
// and a 12/8-bit instance with the timeout disabled.
module tb_io_sequencer_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: ADDR_W 25, DATA_W 16, TIMEOUT_CYC 8
   logic        reset = 1'b0, key0 = 1'b0, key1 = 1'b0, abort_i = 1'b0, done = 1'b0;
   logic [8:0]  sw = '0;
   logic [15:0] rdata = '0;
   logic [1:0]  mode;
   logic [24:0] addr;
   logic [15:0] wdata, disp;
   logic        req, err;
   logic [1:0]  cidx;
   logic [2:0]  st;

   io_sequencer_param #(.ADDR_W(25), .DATA_W(16), .SW_W(9), .TIMEOUT_CYC(8)) dut_a (
      .clk(clk), .reset(reset), .key0_pulse(key0), .key1_pulse(key1), .abort(abort_i),
      .sw(sw), .mem_done(done), .read_data(rdata), .mode(mode), .mem_addr(addr),
      .write_data(wdata), .mem_req(req), .display_data(disp), .chunk_idx(cidx),
      .err(err), .state_out(st));

   // Instance B: ADDR_W 12, DATA_W 8, timeout disabled
   logic        b_reset = 1'b0, b_key0 = 1'b0, b_key1 = 1'b0, b_abort = 1'b0, b_done = 1'b0;
   logic [8:0]  b_sw = '0;
   logic [7:0]  b_rdata = '0;
   logic [1:0]  b_mode;
   logic [11:0] b_addr;
   logic [7:0]  b_wdata, b_disp;
   logic        b_req, b_err;
   logic [1:0]  b_cidx;
   logic [2:0]  b_st;

   io_sequencer_param #(.ADDR_W(12), .DATA_W(8), .SW_W(9), .TIMEOUT_CYC(0)) dut_b (
      .clk(clk), .reset(b_reset), .key0_pulse(b_key0), .key1_pulse(b_key1), .abort(b_abort),
      .sw(b_sw), .mem_done(b_done), .read_data(b_rdata), .mode(b_mode), .mem_addr(b_addr),
      .write_data(b_wdata), .mem_req(b_req), .display_data(b_disp), .chunk_idx(b_cidx),
      .err(b_err), .state_out(b_st));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic k0();           key0 = 1; tick(); key0 = 0; endtask
   task automatic k1(input logic [8:0] v); sw = v; key1 = 1; tick(); key1 = 0; endtask
   task automatic md(input logic [15:0] d); rdata = d; done = 1; tick(); done = 0; endtask
   task automatic bk0();          b_key0 = 1; tick(); b_key0 = 0; endtask
   task automatic bk1(input logic [8:0] v); b_sw = v; b_key1 = 1; tick(); b_key1 = 0; endtask
   task automatic bmd(input logic [7:0] d); b_rdata = d; b_done = 1; tick(); b_done = 0; endtask

   initial begin
      reset = 1; b_reset = 1;
      tick(); tick();
      reset = 0; b_reset = 0;
      chk("rst_state", st, 0);
      chk("rst_mode", mode, 0);
      chk("rst_addr", addr, 0);
      chk("rst_req", req, 0);
      chk("rst_err", err, 0);
      chk("rst_disp", disp, 0);
      chk("rst_cidx", cidx, 0);

      // Read 0x1AB1234
      k0();           chk("sel_read_state", st, 1); chk("sel_read_mode", mode, 1);
      k1(9'h000);     chk("addr_entry_state", st, 3); chk("addr_entry_cidx", cidx, 0);
      k1(9'h034);     chk("chunk0_addr", addr, 25'h34); chk("chunk0_cidx", cidx, 1);
      k1(9'h012);     chk("chunk1_addr", addr, 25'h1234); chk("chunk1_req", req, 0);
      k1(9'h1AB);     chk("rd_addr", addr, 25'h1AB1234); chk("rd_req", req, 1);
                      chk("rd_wait_mode", mode, 1); chk("rd_wait_state", st, 5);
      md(16'hBEEF);   chk("rd_disp", disp, 16'hBEEF); chk("rd_done_state", st, 6);
                      chk("rd_done_mode", mode, 0); chk("rd_done_req", req, 0);
      k0();           chk("rd_exit_state", st, 0); chk("rd_exit_addr", addr, 0);

      // Burst read wrapping from the top address
      k0(); k1(9'h000); k1(9'h0FF); k1(9'h0FF); k1(9'h1FF);
      chk("wrap_addr", addr, 25'h1FFFFFF);
      md(16'h0000);   chk("wrap_done_state", st, 6);
      k1(9'h000);     chk("wrap_inc_addr", addr, 0); chk("wrap_req", req, 1);
      md(16'h1234);   chk("wrap_disp", disp, 16'h1234);
      k0();

      // Write burst
      k0(); k0();     chk("sel_write_state", st, 2); chk("sel_write_mode", mode, 2);
      k1(9'h000); k1(9'h010); k1(9'h000); k1(9'h000);
      chk("wr_data_state", st, 4); chk("wr_addr", addr, 25'h10); chk("wr_cidx", cidx, 0);
      chk("wr_data_mode", mode, 2);
      k1(9'h0CD);     chk("wr_chunk0", wdata, 16'h00CD); chk("wr_chunk0_cidx", cidx, 1);
      k1(9'h0AB);     chk("wr_wdata", wdata, 16'hABCD); chk("wr_req", req, 1); chk("wr_wait_mode", mode, 2);
      md(16'h0000);   chk("wr_burst_state", st, 4); chk("wr_burst_addr", addr, 25'h11);
                      chk("wr_burst_cidx", cidx, 0); chk("wr_burst_wdata", wdata, 16'hABCD);
      k0();           chk("wr_exit_state", st, 0);

      // Timeout after 8 MEM_WAIT cycles
      k0(); k1(9'h000); k1(9'h000); k1(9'h000); k1(9'h000);
      chk("to_wait_state", st, 5);
      for (int i = 0; i < 7; i++) tick();
      chk("to_before_state", st, 5); chk("to_before_err", err, 0);
      tick();
      chk("to_state", st, 7); chk("to_err", err, 1); chk("to_mode", mode, 3); chk("to_req", req, 0);
      k0();           chk("to_exit_state", st, 0); chk("to_exit_err", err, 0);

      // mem_done on the 8th cycle beats the timeout
      k0(); k1(9'h000); k1(9'h000); k1(9'h000); k1(9'h000);
      for (int i = 0; i < 7; i++) tick();
      md(16'h5555);   chk("tie_state", st, 6); chk("tie_err", err, 0); chk("tie_disp", disp, 16'h5555);
      k0();

      // Abort during the second address chunk
      k0(); k1(9'h000); k1(9'h022);
      chk("ab_pre_addr", addr, 25'h22);
      sw = 9'h033; key1 = 1; abort_i = 1; tick(); key1 = 0; abort_i = 0;
      chk("ab_state", st, 0); chk("ab_addr", addr, 0); chk("ab_cidx", cidx, 0);
      chk("ab_disp", disp, 16'h5555);

      // Reset while waiting on memory, then a stray mem_done
      k0(); k1(9'h000); k1(9'h001); k1(9'h002); k1(9'h003);
      chk("rw_req", req, 1);
      reset = 1; tick(); reset = 0;
      chk("rw_state", st, 0); chk("rw_req_low", req, 0); chk("rw_addr", addr, 0);
      chk("rw_disp", disp, 0); chk("rw_wdata", wdata, 0);
      md(16'hFFFF);   chk("stray_state", st, 0); chk("stray_disp", disp, 0);

      // Simultaneous keys: key0 wins
      k0();
      key0 = 1; key1 = 1; tick(); key0 = 0; key1 = 0;
      chk("both_keys_state", st, 2);

      // Instance B: 12-bit address in two chunks, 8-bit data in one
      bk0(); bk1(9'h000);
      bk1(9'h0AB);    chk("b_chunk0_addr", b_addr, 12'h0AB);
      bk1(9'h1F5);    chk("b_rd_addr", b_addr, 12'h5AB); chk("b_rd_state", b_st, 5);
      for (int i = 0; i < 20; i++) tick();
      chk("b_no_timeout_state", b_st, 5); chk("b_no_timeout_err", b_err, 0);
      bmd(8'h77);     chk("b_disp", b_disp, 8'h77);
      bk0();
      bk0(); bk0(); bk1(9'h000);
      bk1(9'h012); bk1(9'h003);
      chk("b_wr_addr", b_addr, 12'h312); chk("b_wr_data_state", b_st, 4);
      bk1(9'h1C6);    chk("b_wdata", b_wdata, 8'hC6); chk("b_wr_wait_state", b_st, 5);
      bmd(8'h00);     chk("b_burst_addr", b_addr, 12'h313); chk("b_burst_state", b_st, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
